// File: rtl/blit_dst_rmw.sv
// Destination read-modify-write sequencer for the blitter inner loop.
// Optional collision abort on a nonzero destination read: define DST_COLLISION_EN.
module blit_dst_rmw #(
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [CW-1:0] CNT,
  input  logic          DSTRD,
  input  logic [3:0]    LFU,
  input  logic [7:0]    SRCD,
  input  logic [7:0]    DSTD,
  input  logic          MACK,
  output logic          MREQ,
  output logic          MWR,
  output logic [7:0]    OD,
  output logic          LDDSTL,
  output logic          ADRINC,
  output logic          BUSY,
  output logic          DONE,
  output logic          COLLIDE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [CW:0] CNT_ONE  = {{CW{1'b0}}, 1'b1};
  localparam logic [CW:0] CNT_FULL = {1'b1, {CW{1'b0}}};

  state_t      state_q, state_d;
  logic [CW:0] cnt_q, cnt_d;
  logic [7:0]  od_q, od_d;
  logic        done_q, done_d;
  logic        lddstl_s;
  logic        adrinc_s;
`ifdef DST_COLLISION_EN
  logic        coll_q, coll_d;
`endif

  // Each OD bit selects one LFU entry using {source bit, destination bit} as index.
  function automatic logic [7:0] lfu_apply(input logic [3:0] f, input logic [7:0] s,
                                           input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = f[{s[i], d[i]}];
    end
    return r;
  endfunction

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= {(CW+1){1'b0}};
      od_q    <= 8'h00;
      done_q  <= 1'b0;
`ifdef DST_COLLISION_EN
      coll_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      od_q    <= od_d;
      done_q  <= done_d;
`ifdef DST_COLLISION_EN
      coll_q  <= coll_d;
`endif
    end
  end

  // Next-state, count, write data and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    lddstl_s = 1'b1;
    adrinc_s = 1'b0;
`ifdef DST_COLLISION_EN
    coll_d   = coll_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          cnt_d   = (CNT == {CW{1'b0}}) ? CNT_FULL : {1'b0, CNT};
          state_d = DSTRD ? S_READ : S_WRITE;
`ifdef DST_COLLISION_EN
          coll_d  = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (MACK) begin
          // Latch is transparent this cycle, so DSTD already shows the fetched data.
          lddstl_s = 1'b0;
`ifdef DST_COLLISION_EN
          if (DSTD != 8'h00) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            coll_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
`else
          state_d = S_WRITE;
`endif
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (MACK) begin
          adrinc_s = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DSTRD ? S_READ : S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_WRITE) begin
      od_d = lfu_apply(LFU, SRCD, DSTD);
    end else begin
      od_d = od_q;
    end
  end

  assign MREQ   = (state_q != S_IDLE);
  assign BUSY   = (state_q != S_IDLE);
  assign MWR    = (state_q == S_WRITE);
  assign OD     = od_q;
  assign DONE   = done_q;
  assign LDDSTL = lddstl_s;
  assign ADRINC = adrinc_s;
`ifdef DST_COLLISION_EN
  assign COLLIDE = coll_q;
`else
  assign COLLIDE = 1'b0;
`endif

endmodule

// File: tb/tb_blit_dst_rmw.sv
// Randomized bench for blit_dst_rmw: a behavioural loop model with a transparent
// destination latch, per-access scoreboard and per-loop transfer/cycle totals.
module tb_blit_dst_rmw;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] CNT = 8'h00;
  logic       DSTRD = 1'b0;
  logic [3:0] LFU = 4'h0;
  logic [7:0] SRCD = 8'h00;
  logic       MACK = 1'b0;
  logic [7:0] id_v = 8'h00;
  logic [7:0] dstd_l = 8'h00;
  logic       MREQ, MWR, LDDSTL, ADRINC, BUSY, DONE, COLLIDE;
  logic [7:0] OD;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] dst_m = 8'h00;
  logic [7:0] last_od = 8'h00;

`ifdef DST_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  blit_dst_rmw #(.CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CNT(CNT), .DSTRD(DSTRD), .LFU(LFU),
    .SRCD(SRCD), .DSTD(dstd_l), .MACK(MACK), .MREQ(MREQ), .MWR(MWR), .OD(OD),
    .LDDSTL(LDDSTL), .ADRINC(ADRINC), .BUSY(BUSY), .DONE(DONE), .COLLIDE(COLLIDE)
  );

  always #5 CLK = ~CLK;

  // Destination data register: transparent while LDDSTL is low.
  always_latch begin
    if (!LDDSTL) dstd_l <= id_v;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Logic function as a sum of the four selected minterms.
  function automatic logic [7:0] lfu_ref(input logic [3:0] f, input logic [7:0] s,
                                         input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    if (f[3]) r = r | (s & d);
    if (f[2]) r = r | (s & ~d);
    if (f[1]) r = r | (~s & d);
    if (f[0]) r = r | (~s & ~d);
    return r;
  endfunction

  task automatic idle(input int k);
    START = 1'b0;
    MACK  = 1'b0;
    repeat (k) @(negedge CLK);
  endtask

  // One inner loop, started at the current negedge (DUT idle or on its DONE cycle).
  task automatic run_loop(input int cnt, input bit dstrd, input logic [3:0] lfu,
                          input logic [7:0] srcd, input int dlo, input int dhi,
                          input int first_d, input int fix_id, input int coll_at);
    int n, rd, wr, adr, ld, busy, exp_busy, wt, tgt, cyc, budget, exp_w, exp_r;
    bit want_rd, aborted, done_seen;
    logic [7:0] cur_id;
    n = (cnt == 0) ? 256 : cnt;
    rd = 0; wr = 0; adr = 0; ld = 0; busy = 0; exp_busy = 0; wt = 0; cyc = 0;
    want_rd = dstrd; aborted = 1'b0; done_seen = 1'b0; cur_id = 8'h00;
    tgt = (first_d >= 0) ? first_d : int'($urandom_range(dhi, dlo));
    budget = n * 2 * (((first_d > dhi) ? first_d : dhi) + 1) + 20;
    START = 1'b1; CNT = 8'(cnt); DSTRD = dstrd; LFU = lfu; SRCD = srcd; MACK = 1'b0;
    while (!done_seen && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      MACK = 1'b0;
      if (cyc == 1) begin
        check_eq("start_mreq", 32'(MREQ), 32'd1);
        check_eq("done_pulse", 32'(DONE), 32'd0);
        check_eq("coll_clear", 32'(COLLIDE), 32'd0);
      end
      if (DONE) begin
        done_seen = 1'b1;
        START = 1'b0;
        check_eq("done_busy", 32'(BUSY), 32'd0);
        check_eq("done_coll", 32'(COLLIDE), 32'(aborted));
      end else begin
        if (BUSY) busy++;
        check_eq("mreq_hold", 32'(MREQ), 32'd1);
        check_eq("kind", 32'(MWR), 32'(!want_rd));
        START = ($urandom_range(7, 0) == 0);
        CNT = 8'($urandom);
        if (wt == 0 && want_rd) begin
          if (fix_id >= 0) cur_id = 8'(fix_id);
          else if (COLL_EN) cur_id = (rd == coll_at) ? 8'h01 : 8'h00;
          else cur_id = 8'($urandom);
          id_v = cur_id;
        end
        MACK = (wt == tgt);
        #1;
        if (!LDDSTL) ld++;
        if (ADRINC) adr++;
        if (MACK) begin
          exp_busy += tgt + 1;
          if (want_rd) begin
            rd++;
            dst_m = cur_id;
            check_eq("ld_on_read", 32'(LDDSTL), 32'd0);
            if (COLL_EN && cur_id != 8'h00) aborted = 1'b1;
            else want_rd = 1'b0;
          end else begin
            wr++;
            check_eq("od", 32'(OD), 32'(lfu_ref(lfu, srcd, dst_m)));
            last_od = OD;
            want_rd = dstrd;
          end
          wt = 0;
          tgt = int'($urandom_range(dhi, dlo));
        end else begin
          wt++;
          check_eq("ld_wait", 32'(LDDSTL), 32'd1);
          check_eq("adr_wait", 32'(ADRINC), 32'd0);
        end
      end
    end
    MACK = 1'b0;
    START = 1'b0;
    check_eq("timeout", 32'(done_seen), 32'd1);
    exp_w = aborted ? rd - 1 : n;
    exp_r = dstrd ? (aborted ? rd : n) : 0;
    check_eq("writes", 32'(wr), 32'(exp_w));
    check_eq("adrinc", 32'(adr), 32'(exp_w));
    check_eq("lddstl", 32'(ld), 32'(exp_r));
    check_eq("busy", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("rst_mreq", 32'(MREQ), 32'd0);
    check_eq("rst_mwr", 32'(MWR), 32'd0);
    check_eq("rst_od", 32'(OD), 32'd0);
    check_eq("rst_ld", 32'(LDDSTL), 32'd1);
    check_eq("rst_adr", 32'(ADRINC), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_coll", 32'(COLLIDE), 32'd0);
    RESET = 1'b0;
    idle(2);

    // Reset in the middle of an acknowledged write.
    START = 1'b1; CNT = 8'd5; DSTRD = 1'b0; LFU = 4'hC; SRCD = 8'h11;
    @(negedge CLK);
    START = 1'b0;
    check_eq("mw_mreq", 32'(MREQ), 32'd1);
    check_eq("mw_mwr", 32'(MWR), 32'd1);
    MACK = 1'b1;
    #1;
    check_eq("mw_adr_pre", 32'(ADRINC), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    check_eq("mr_mreq", 32'(MREQ), 32'd0);
    check_eq("mr_busy", 32'(BUSY), 32'd0);
    check_eq("mr_ld", 32'(LDDSTL), 32'd1);
    check_eq("mr_adr", 32'(ADRINC), 32'd0);
    check_eq("mr_od", 32'(OD), 32'd0);
    MACK = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    idle(3);
    check_eq("mr_idle", 32'(MREQ), 32'd0);

    // Three read-modify-write transfers, MACK one cycle after each request.
    run_loop(3, 1'b1, 4'b0110, 8'hF0, 1, 1, 1, 8'hAA, -1);
    check_eq("rmw_od", 32'(last_od), 32'h5A);
    idle(3);

    // CNT=0: full 256 write-only transfers with copy function.
    run_loop(0, 1'b0, 4'b1100, 8'h3C, 0, 1, -1, -1, -1);
    check_eq("copy_od", 32'(last_od), 32'h3C);
    idle(2);

    // Long memory stall on the first read.
    run_loop(2, 1'b1, 4'($urandom), 8'($urandom), 0, 2, 20, -1, -1);

    // Back-to-back loop started on the DONE cycle.
    run_loop(4, 1'b0, 4'($urandom), 8'($urandom), 0, 2, -1, -1, -1);
    run_loop(3, 1'b1, 4'($urandom), 8'($urandom), 0, 2, -1, -1, -1);
    idle(2);

`ifdef DST_COLLISION_EN
    run_loop(4, 1'b1, 4'b1010, 8'h55, 0, 2, -1, -1, 1);
    idle(3);
    check_eq("coll_hold", 32'(COLLIDE), 32'd1);
    run_loop(2, 1'b1, 4'b1010, 8'h55, 0, 1, -1, -1, -1);
    idle(2);
`endif

    for (int it = 0; it < 14; it++) begin
      run_loop(int'($urandom_range(16, 1)), 1'($urandom), 4'($urandom), 8'($urandom),
               0, int'($urandom_range(3, 0)), -1, -1, -1);
      if ($urandom_range(1, 0) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
